// File: rtl/pc_sequencer_pkg.sv
// Shared defaults and types for the PC sequencer and its return-address stack.
package pc_sequencer_pkg;

  localparam int PW_DEF        = 32;
  localparam int IMMW_DEF      = 16;
  localparam int DW_DEF        = 32;
  localparam int RAS_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Aliases kept for blocks that still use the older parameter names.
  localparam int Pb      = PW_DEF;
  localparam int ImmBits = IMMW_DEF;
  localparam int N       = DW_DEF;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JIMM,
    SRC_JREG,
    SRC_RAS
  } next_src_t;

  // BEQ takes on zero, BNE takes on non-zero.
  function automatic logic branch_taken(input logic beq_bne, input logic zero);
    return beq_bne ^ zero;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: push, pop and replace-top, with overflow and
// underflow event flags (combinational; the parent registers them).
module pc_sequencer_ras
  import pc_sequencer_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int WIDTH = PW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic             full;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign top_o   = mem_q[top_q];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    top_d       = top_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_idx      = top_q + PTR_W'(1);
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (en_i) begin
      unique case ({push_i, pop_i})
        2'b10: begin
          // When full, top+1 is the oldest slot, so the write evicts it.
          wr_en = 1'b1;
          top_d = top_q + PTR_W'(1);
          if (full) overflow_o = 1'b1;
          else      cnt_d      = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          if (empty_o) begin
            underflow_o = 1'b1;
          end else begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        2'b11: begin
          if (empty_o) begin
            // Nothing to replace: the return misses and the call still pushes.
            underflow_o = 1'b1;
            wr_en       = 1'b1;
            top_d       = top_q + PTR_W'(1);
            cnt_d       = cnt_q + CNT_W'(1);
          end else begin
            wr_en  = 1'b1;
            wr_idx = top_q;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the entry array has no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch/jump target selection and a return-address
// stack. Define PC_PERF_CNT_EN to add taken_cnt / ras_hit_cnt performance counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int            PW        = PW_DEF,
  parameter int            IMMW      = IMMW_DEF,
  parameter int            DW        = DW_DEF,
  parameter int            RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [PW-1:0] RESET_PC  = PW'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch,
  input  logic            beq_bne,
  input  logic            zero,
  input  logic            jmp,
  input  logic            jmp_reg,
  input  logic            link,
  input  logic            ret,
  input  logic [IMMW-1:0] imm,
  input  logic [DW-1:0]   qs,
  output logic [PW-1:0]   pc,
  output logic [PW-1:0]   pc_plus4,
  output logic            ras_overflow,
  output logic            ras_underflow,
  output logic            misalign
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0]     taken_cnt,
  output logic [31:0]     ras_hit_cnt
`endif
);

  logic [PW-1:0] pc_q, pc_d;
  logic          ovf_q, unf_q, mis_q;
  logic [PW-1:0] br_tgt, jimm_tgt, jreg_tgt, ras_top;
  logic [PW-1:0] imm_sext;
  logic          ras_empty, ras_ovf, ras_unf, mis_d;
  next_src_t     src;

  assign pc_plus4 = pc_q + PW'(4);
  assign imm_sext = {{(PW-IMMW){imm[IMMW-1]}}, imm};
  assign br_tgt   = pc_plus4 + (imm_sext << 2);
  assign jimm_tgt = {pc_plus4[PW-1:IMMW+2], imm, 2'b00};
  assign jreg_tgt = {qs[PW-1:2], 2'b00};

  always_comb begin
    src = SRC_SEQ;
    if (ret && !ras_empty)                src = SRC_RAS;
    else if (ret)                         src = SRC_JREG;
    else if (jmp)                         src = jmp_reg ? SRC_JREG : SRC_JIMM;
    else if (branch && branch_taken(beq_bne, zero)) src = SRC_BR;
  end

  always_comb begin
    pc_d = pc_plus4;
    unique case (src)
      SRC_RAS:  pc_d = ras_top;
      SRC_JREG: pc_d = jreg_tgt;
      SRC_JIMM: pc_d = jimm_tgt;
      SRC_BR:   pc_d = br_tgt;
      default:  pc_d = pc_plus4;
    endcase
  end

  assign mis_d = (src == SRC_JREG) && (qs[1:0] != 2'b00);

  pc_sequencer_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PW)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (!stall),
    .push_i      (link),
    .pop_i       (ret),
    .din_i       (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .overflow_o  (ras_ovf),
    .underflow_o (ras_unf)
  );

  // Pulses are registered so they line up with the pc they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else if (stall) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ras_ovf;
      unf_q <= ras_unf;
      mis_q <= mis_d;
    end
  end

  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign misalign      = mis_q;

`ifdef PC_PERF_CNT_EN
  logic [31:0] taken_q, hit_q;

  // Any non-sequential redirect (branch, jump or return) counts as taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_q <= '0;
      hit_q   <= '0;
    end else if (!stall) begin
      if (src != SRC_SEQ && taken_q != '1) taken_q <= taken_q + 32'd1;
      if (src == SRC_RAS && hit_q != '1)   hit_q   <= hit_q + 32'd1;
    end
  end

  assign taken_cnt   = taken_q;
  assign ras_hit_cnt = hit_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter sequencer for the single-cycle/multicycle MIPS core. It owns the PC register and computes next-PC from sequential, BEQ/BNE branch, J-type immediate and JR register-jump requests. It adds a stall input and a hardware return-address stack (RAS) that predicts `jr $ra` targets for JAL/JR call-return pairs. It sits between the control unit / register file and the instruction memory address port.

Parameters:
PW, 32, PC width in bits
IMMW, 16, immediate field width
DW, 32, register data width (Qs)
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hold PC and RAS this cycle
branch  in  1  conditional branch instruction
beq_bne  in  1  0 = BEQ, 1 = BNE
zero  in  1  ALU zero flag
jmp  in  1  unconditional jump
jmp_reg  in  1  with jmp: 0 = immediate target, 1 = Qs target
link  in  1  call (JAL/JALR): push return address
ret  in  1  return (JR $ra): pop RAS for target
imm  in  IMMW  immediate field
qs  in  DW  register-file source operand
pc  out  PW  current PC (registered)
pc_plus4  out  PW  pc + 4, combinational
ras_overflow  out  1  one-cycle pulse: push while full
ras_underflow  out  1  one-cycle pulse: ret while empty
misalign  out  1  one-cycle pulse: register target with bits[1:0] != 0

Behaviour:
- Reset:
  - On a clk edge with rst_n = 0: pc = RESET_PC, RAS count = 0, top pointer = 0.
  - All pulse outputs are 0. Reset overrides stall and every request.
- Update rule: pc updates every cycle with stall = 0. With stall = 1, pc, RAS and all pulses hold or clear to 0; requests are ignored.
- Target arithmetic (all modulo 2^PW, wrap-around silent):
  - Branch target = pc_plus4 + (sign_extend(imm) << 2).
  - J immediate = {pc_plus4[PW-1:IMMW+2], imm, 2'b00}.
  - J register = qs[PW-1:0] with bits[1:0] forced to 0; misalign pulses if the original bits were nonzero.
- Next-PC priority, highest first:
  1. ret with RAS non-empty: pop top.
  2. ret with RAS empty: use qs (register path); ras_underflow pulses.
  3. jmp: jmp_reg selects the register or immediate target.
  4. branch taken: (beq_bne = 0 and zero = 1) or (beq_bne = 1 and zero = 0).
  5. Otherwise pc_plus4.
- RAS, a circular buffer of RAS_DEPTH entries:
  - Push: link = 1 writes pc_plus4 at top+1 and increments count.
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH; ras_overflow pulses.
  - Pop: decrements count; an empty pop does not move the pointer.
  - link and ret in the same cycle: replace top with pc_plus4, count unchanged, pc = old top.
- Latency: request to new pc = 1 cycle; pc_plus4 follows pc combinationally.

Optional Feature:
PC_PERF_CNT_EN
- Defined:
  - Adds 32-bit outputs taken_cnt (taken branches + jumps) and ras_hit_cnt (returns served from a non-empty RAS).
  - Counters increment only when stall = 0, clear on reset and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counter logic are absent; core behaviour is identical.

Decomposition:
- the_pkg holds:
  - PW/IMMW/DW defaults (aliases of Pb, ImmBits, N).
  - RAS_DEPTH_DEF.
  - typedef enum next_src_t {SRC_SEQ, SRC_BR, SRC_JIMM, SRC_JREG, SRC_RAS}.
  - RESET_PC_DEF.
- One sub-module, ras_stack: push/pop/replace, count, overflow/underflow, parametrised by depth and width.
- Target selection stays in pc_sequencer.

Test Plan:
- Reset: rst_n = 0 for 2 cycles, then release → pc = 0, 4, 8 on the following edges; pulses stay 0.
- Branch: pc = 0x100, branch = 1, beq_bne = 0, zero = 1, imm = 16'hFFFE → pc = 0x0FC. Same with zero = 0 → pc = 0x104.
- BNE and jumps:
  - BNE with zero = 0, imm = 3 → pc = 0x100 + 4 + 12 = 0x110.
  - jmp_reg with qs = 0x2002 → pc = 0x2000, misalign = 1.
- RAS round trip (RAS_DEPTH = 4):
  - Five link calls from pc = 0x10, 0x20, 0x30, 0x40, 0x50 → ras_overflow on the 5th.
  - Five rets → 0x54, 0x44, 0x34, 0x24.
  - 5th ret → qs target and ras_underflow.
- Stall: stall = 1 for 3 cycles with jmp asserted → pc frozen, RAS unchanged. Release → jump taken in 1 cycle.
- Simultaneous link + ret with top = 0x80 at pc = 0x200 → pc = 0x80, top = 0x204, count unchanged. Then reset mid-sequence → pc = RESET_PC, RAS empty.
